// File: rtl/ysyx_22051013_idu_decq.sv
// Decode queue: buffers fetched {pc,inst} pairs in a small circular FIFO and presents
// one decoded RV32I/RV64I instruction per handshake from a registered output stage.
module ysyx_22051013_idu_decq #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rs1_ena,
  output logic            out_rs2_ena,
  output logic            out_imm_ena,
  output logic            out_load,
  output logic            out_store,
  output logic            out_branch,
  output logic            out_jump,
  output logic [1:0]      out_wb_ctl,
  output logic [3:0]      out_mem_ctl,
  output logic [XLEN-1:0] out_ext_imm,
  output logic            out_illegal
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam bit          Rv64 = (XLEN == 64);

  // Major opcodes, inst[6:2]
  localparam logic [4:0] OpLoad    = 5'b00000;
  localparam logic [4:0] OpOpImm   = 5'b00100;
  localparam logic [4:0] OpAuipc   = 5'b00101;
  localparam logic [4:0] OpOpImm32 = 5'b00110;
  localparam logic [4:0] OpStore   = 5'b01000;
  localparam logic [4:0] OpOp      = 5'b01100;
  localparam logic [4:0] OpLui     = 5'b01101;
  localparam logic [4:0] OpOp32    = 5'b01110;
  localparam logic [4:0] OpBranch  = 5'b11000;
  localparam logic [4:0] OpJalr    = 5'b11001;
  localparam logic [4:0] OpJal     = 5'b11011;
  localparam logic [4:0] OpSystem  = 5'b11100;

  typedef struct packed {
    logic            rs1_ena;
    logic            rs2_ena;
    logic            imm_ena;
    logic            load;
    logic            store;
    logic            branch;
    logic            jump;
    logic [1:0]      wb_ctl;
    logic [3:0]      mem_ctl;
    logic [XLEN-1:0] ext_imm;
  } ctl_t;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q;
  logic [31:0]     out_inst_q;
  ctl_t            out_ctl_q;
  logic            out_illegal_q;

  logic            push, pop, empty;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_inst;
  logic [2:0]      f3;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  logic            bad;
  ctl_t            dec_ctl;
  logic            dec_illegal;

  assign in_ready = (count_q < CntW'(DEPTH)) & ~rst;
  assign empty    = (count_q == '0);
  assign push     = in_valid & in_ready & ~flush;
  // Refill the stage whenever it is empty or being consumed this cycle.
  assign pop      = ~flush & ~empty & (~out_valid_q | out_ready);

  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign head_inst = inst_mem_q[rd_ptr_q];
  assign f3        = head_inst[14:12];

  assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
  assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
  assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                  head_inst[11:8], 1'b0};
  assign imm_u = {head_inst[31:12], 12'b0};
  assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                  head_inst[30:21], 1'b0};

  always_comb begin
    dec_ctl     = '0;
    dec_illegal = 1'b0;
    imm_sel     = '0;
    bad         = 1'b0;
    unique case (head_inst[6:2])
      OpLoad: begin
        dec_ctl.load    = 1'b1;
        dec_ctl.rs1_ena = 1'b1;
        dec_ctl.imm_ena = 1'b1;
        dec_ctl.wb_ctl  = 2'b01;
        imm_sel         = imm_i;
        unique case (f3)
          3'b000:  dec_ctl.mem_ctl = 4'b1001;
          3'b001:  dec_ctl.mem_ctl = 4'b1010;
          3'b010:  dec_ctl.mem_ctl = 4'b1011;
          3'b011:  begin dec_ctl.mem_ctl = 4'b1100; bad = ~Rv64; end
          3'b100:  dec_ctl.mem_ctl = 4'b1101;
          3'b101:  dec_ctl.mem_ctl = 4'b1110;
          3'b110:  begin dec_ctl.mem_ctl = 4'b1111; bad = ~Rv64; end
          default: bad = 1'b1;
        endcase
      end
      OpStore: begin
        dec_ctl.store   = 1'b1;
        dec_ctl.rs1_ena = 1'b1;
        dec_ctl.rs2_ena = 1'b1;
        dec_ctl.imm_ena = 1'b1;
        imm_sel         = imm_s;
        unique case (f3)
          3'b000:  dec_ctl.mem_ctl = 4'b0001;
          3'b001:  dec_ctl.mem_ctl = 4'b0010;
          3'b010:  dec_ctl.mem_ctl = 4'b0100;
          3'b011:  begin dec_ctl.mem_ctl = 4'b0101; bad = ~Rv64; end
          default: bad = 1'b1;
        endcase
      end
      OpOpImm, OpOpImm32: begin
        dec_ctl.rs1_ena = 1'b1;
        dec_ctl.imm_ena = 1'b1;
        dec_ctl.wb_ctl  = 2'b10;
        imm_sel         = imm_i;
        if (head_inst[6:2] == OpOpImm32) begin
          bad = ~Rv64 | ~(f3 inside {3'b000, 3'b001, 3'b101});
        end
      end
      OpOp, OpOp32: begin
        dec_ctl.rs1_ena = 1'b1;
        dec_ctl.rs2_ena = 1'b1;
        dec_ctl.wb_ctl  = 2'b10;
        if (head_inst[6:2] == OpOp32) begin
          bad = ~Rv64 | ~(f3 inside {3'b000, 3'b001, 3'b101});
        end
      end
      OpBranch: begin
        dec_ctl.branch  = 1'b1;
        dec_ctl.rs1_ena = 1'b1;
        dec_ctl.rs2_ena = 1'b1;
        imm_sel         = imm_b;
        bad             = (f3[2:1] == 2'b01);
      end
      OpJal: begin
        dec_ctl.jump   = 1'b1;
        dec_ctl.wb_ctl = 2'b10;
        imm_sel        = imm_j;
      end
      OpJalr: begin
        dec_ctl.jump    = 1'b1;
        dec_ctl.rs1_ena = 1'b1;
        dec_ctl.wb_ctl  = 2'b10;
        imm_sel         = imm_i;
        bad             = (f3 != 3'b000);
      end
      OpLui, OpAuipc: begin
        dec_ctl.imm_ena = 1'b1;
        dec_ctl.wb_ctl  = 2'b10;
        imm_sel         = imm_u;
      end
      OpSystem: begin
        // Only the register-sourced CSR ops read rs1.
        dec_ctl.rs1_ena = f3 inside {3'b001, 3'b010, 3'b011};
        dec_ctl.imm_ena = 1'b1;
        dec_ctl.wb_ctl  = 2'b10;
        imm_sel         = imm_i;
        bad             = (f3 == 3'b100);
      end
      default: bad = 1'b1;
    endcase
    if (head_inst[1:0] != 2'b11) bad = 1'b1;
    dec_ctl.ext_imm = XLEN'($signed(imm_sel));
    dec_illegal     = bad;
    if (bad) dec_ctl = '0;
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (pop) begin
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= in_pc;
      inst_mem_q[wr_ptr_q] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_inst_q    <= '0;
      out_ctl_q     <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      if (pop) begin
        out_pc_q      <= head_pc;
        out_inst_q    <= head_inst;
        out_ctl_q     <= dec_ctl;
        out_illegal_q <= dec_illegal;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_inst    = out_inst_q;
  assign out_rd      = out_inst_q[11:7];
  assign out_rs1     = out_inst_q[19:15];
  assign out_rs2     = out_inst_q[24:20];
  assign out_rs1_ena = out_ctl_q.rs1_ena;
  assign out_rs2_ena = out_ctl_q.rs2_ena;
  assign out_imm_ena = out_ctl_q.imm_ena;
  assign out_load    = out_ctl_q.load;
  assign out_store   = out_ctl_q.store;
  assign out_branch  = out_ctl_q.branch;
  assign out_jump    = out_ctl_q.jump;
  assign out_wb_ctl  = out_ctl_q.wb_ctl;
  assign out_mem_ctl = out_ctl_q.mem_ctl;
  assign out_ext_imm = out_ctl_q.ext_imm;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_ysyx_22051013_idu_decq.sv
// Bench for the decode queue: RV64 and RV32 instances share one stimulus stream and are
// compared every cycle against a queue-level model and an arithmetic decode reference.
module tb_ysyx_22051013_idu_decq;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } item_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1i;
    logic [4:0]  rs2i;
    logic        rs1_ena;
    logic        rs2_ena;
    logic        imm_ena;
    logic        ld;
    logic        st;
    logic        br;
    logic        jmp;
    logic [1:0]  wb;
    logic [3:0]  mem;
    logic        ill;
    logic [63:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;

  logic        a_in_ready, a_out_valid, a_rs1_ena, a_rs2_ena, a_imm_ena;
  logic        a_load, a_store, a_branch, a_jump, a_illegal;
  logic [63:0] a_pc, a_imm;
  logic [31:0] a_inst;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [1:0]  a_wb;
  logic [3:0]  a_mem;

  logic        b_in_ready, b_out_valid, b_rs1_ena, b_rs2_ena, b_imm_ena;
  logic        b_load, b_store, b_branch, b_jump, b_illegal;
  logic [31:0] b_pc, b_imm;
  logic [31:0] b_inst;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [1:0]  b_wb;
  logic [3:0]  b_mem;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_emit   = 0;

  item_t fifo[$];
  item_t stage;
  bit    stage_v = 1'b0;

  always #5 clk = ~clk;

  ysyx_22051013_idu_decq #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_inst(a_inst), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_rs1_ena(a_rs1_ena), .out_rs2_ena(a_rs2_ena), .out_imm_ena(a_imm_ena),
    .out_load(a_load), .out_store(a_store), .out_branch(a_branch), .out_jump(a_jump),
    .out_wb_ctl(a_wb), .out_mem_ctl(a_mem), .out_ext_imm(a_imm), .out_illegal(a_illegal)
  );

  ysyx_22051013_idu_decq #(.XLEN(32), .DEPTH(DEPTH)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc[31:0]),
    .in_inst(in_inst), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_inst(b_inst), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_rs1_ena(b_rs1_ena), .out_rs2_ena(b_rs2_ena), .out_imm_ena(b_imm_ena),
    .out_load(b_load), .out_store(b_store), .out_branch(b_branch), .out_jump(b_jump),
    .out_wb_ctl(b_wb), .out_mem_ctl(b_mem), .out_ext_imm(b_imm), .out_illegal(b_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Two's-complement value of an nbits-wide field, truncated to the datapath width.
  function automatic logic [63:0] sext(input longint v, input int nbits, input int xlen);
    longint      s;
    logic [63:0] r;
    s = v;
    if (s >= (longint'(1) << (nbits - 1))) s = s - (longint'(1) << nbits);
    r = 64'(s);
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  function automatic exp_t ref_dec(input logic [63:0] pc, input logic [31:0] i,
                                   input int xlen);
    exp_t        e;
    exp_t        keep;
    logic [7:0]  ok;
    int          f3;
    longint      vi, vs, vb, vj, vu;
    bit          w64;
    w64 = (xlen == 64);
    f3  = int'(i[14:12]);
    vi  = longint'(i[31:20]);
    vs  = longint'(i[31:25]) * 32 + longint'(i[11:7]);
    vb  = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
          + longint'(i[11:8]) * 2;
    vj  = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
          + longint'(i[30:21]) * 2;
    vu  = longint'(i[31:12]) * 4096;
    e      = '0;
    e.pc   = w64 ? pc : {32'h0, pc[31:0]};
    e.inst = i;
    e.rd   = i[11:7];
    e.rs1i = i[19:15];
    e.rs2i = i[24:20];
    ok     = 8'h00;
    case (i[6:0])
      7'h03: begin
        ok = w64 ? 8'h7F : 8'h37;
        e.ld = 1; e.rs1_ena = 1; e.imm_ena = 1; e.wb = 2'd1;
        e.mem = 4'(9 + f3); e.imm = sext(vi, 12, xlen);
      end
      7'h23: begin
        ok = w64 ? 8'h0F : 8'h07;
        e.st = 1; e.rs1_ena = 1; e.rs2_ena = 1; e.imm_ena = 1;
        e.mem = (f3 == 0) ? 4'd1 : (f3 == 1) ? 4'd2 : (f3 == 2) ? 4'd4 : 4'd5;
        e.imm = sext(vs, 12, xlen);
      end
      7'h13, 7'h1B: begin
        ok = (i[6:0] == 7'h13) ? 8'hFF : (w64 ? 8'h23 : 8'h00);
        e.rs1_ena = 1; e.imm_ena = 1; e.wb = 2'd2; e.imm = sext(vi, 12, xlen);
      end
      7'h33, 7'h3B: begin
        ok = (i[6:0] == 7'h33) ? 8'hFF : (w64 ? 8'h23 : 8'h00);
        e.rs1_ena = 1; e.rs2_ena = 1; e.wb = 2'd2;
      end
      7'h63: begin
        ok = 8'hF3;
        e.br = 1; e.rs1_ena = 1; e.rs2_ena = 1; e.imm = sext(vb, 13, xlen);
      end
      7'h6F: begin
        ok = 8'hFF; e.jmp = 1; e.wb = 2'd2; e.imm = sext(vj, 21, xlen);
      end
      7'h67: begin
        ok = 8'h01; e.jmp = 1; e.rs1_ena = 1; e.wb = 2'd2; e.imm = sext(vi, 12, xlen);
      end
      7'h37, 7'h17: begin
        ok = 8'hFF; e.imm_ena = 1; e.wb = 2'd2; e.imm = sext(vu, 32, xlen);
      end
      7'h73: begin
        ok = 8'hEF; e.imm_ena = 1; e.wb = 2'd2; e.imm = sext(vi, 12, xlen);
        e.rs1_ena = (f3 >= 1 && f3 <= 3);
      end
      default: ok = 8'h00;
    endcase
    if (!ok[f3]) begin
      keep = e;
      e = '0;
      e.pc = keep.pc; e.inst = keep.inst;
      e.rd = keep.rd; e.rs1i = keep.rs1i; e.rs2i = keep.rs2i;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t observe64();
    exp_t o;
    o.pc = a_pc; o.inst = a_inst; o.rd = a_rd; o.rs1i = a_rs1; o.rs2i = a_rs2;
    o.rs1_ena = a_rs1_ena; o.rs2_ena = a_rs2_ena; o.imm_ena = a_imm_ena;
    o.ld = a_load; o.st = a_store; o.br = a_branch; o.jmp = a_jump;
    o.wb = a_wb; o.mem = a_mem; o.ill = a_illegal; o.imm = a_imm;
    return o;
  endfunction

  function automatic exp_t observe32();
    exp_t o;
    o.pc = {32'h0, b_pc}; o.inst = b_inst; o.rd = b_rd; o.rs1i = b_rs1; o.rs2i = b_rs2;
    o.rs1_ena = b_rs1_ena; o.rs2_ena = b_rs2_ena; o.imm_ena = b_imm_ena;
    o.ld = b_load; o.st = b_store; o.br = b_branch; o.jmp = b_jump;
    o.wb = b_wb; o.mem = b_mem; o.ill = b_illegal; o.imm = {32'h0, b_imm};
    return o;
  endfunction

  task automatic cmp(input string p, input exp_t o, input exp_t e);
    chk({p, "_pc"}, o.pc, e.pc);
    chk({p, "_inst"}, 64'(o.inst), 64'(e.inst));
    chk({p, "_rd"}, 64'(o.rd), 64'(e.rd));
    chk({p, "_rs1"}, 64'(o.rs1i), 64'(e.rs1i));
    chk({p, "_rs2"}, 64'(o.rs2i), 64'(e.rs2i));
    chk({p, "_rs1_ena"}, 64'(o.rs1_ena), 64'(e.rs1_ena));
    chk({p, "_rs2_ena"}, 64'(o.rs2_ena), 64'(e.rs2_ena));
    chk({p, "_imm_ena"}, 64'(o.imm_ena), 64'(e.imm_ena));
    chk({p, "_load"}, 64'(o.ld), 64'(e.ld));
    chk({p, "_store"}, 64'(o.st), 64'(e.st));
    chk({p, "_branch"}, 64'(o.br), 64'(e.br));
    chk({p, "_jump"}, 64'(o.jmp), 64'(e.jmp));
    chk({p, "_wb_ctl"}, 64'(o.wb), 64'(e.wb));
    chk({p, "_mem_ctl"}, 64'(o.mem), 64'(e.mem));
    chk({p, "_illegal"}, 64'(o.ill), 64'(e.ill));
    chk({p, "_ext_imm"}, o.imm, e.imm);
  endtask

  task automatic check_cycle();
    bit exp_rdy;
    exp_rdy = !rst && (fifo.size() < DEPTH);
    chk("in_ready64", 64'(a_in_ready), 64'(exp_rdy));
    chk("in_ready32", 64'(b_in_ready), 64'(exp_rdy));
    chk("out_valid64", 64'(a_out_valid), 64'(stage_v));
    chk("out_valid32", 64'(b_out_valid), 64'(stage_v));
    if (stage_v) begin
      cmp("d64", observe64(), ref_dec(stage.pc, stage.inst, 64));
      cmp("d32", observe32(), ref_dec(stage.pc, stage.inst, 32));
    end
  endtask

  // Advance the model across the coming edge using the inputs now applied.
  task automatic step();
    item_t it;
    bit    do_push, do_load;
    it.pc   = in_pc;
    it.inst = in_inst;
    if (in_valid && a_in_ready && !flush) n_acc++;
    if (a_out_valid && out_ready) n_emit++;
    if (!rst) begin
      if (flush) begin
        fifo.delete();
        stage_v = 1'b0;
      end else begin
        do_push = in_valid && (fifo.size() < DEPTH);
        do_load = (fifo.size() > 0) && (!stage_v || out_ready);
        if (do_load) begin
          stage   = fifo.pop_front();
          stage_v = 1'b1;
        end else if (out_ready) begin
          stage_v = 1'b0;
        end
        if (do_push) fifo.push_back(it);
      end
    end
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  // Push one instruction into an idle queue; returns with it visible in the stage.
  task automatic send(input logic [31:0] inst);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = {$urandom(), $urandom()};
    in_inst   = inst;
    step();
    in_valid  = 1'b0;
    step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 13))
      0:  r[6:0] = 7'h03;
      1:  r[6:0] = 7'h23;
      2:  r[6:0] = 7'h13;
      3:  r[6:0] = 7'h1B;
      4:  r[6:0] = 7'h33;
      5:  r[6:0] = 7'h3B;
      6:  r[6:0] = 7'h63;
      7:  r[6:0] = 7'h6F;
      8:  r[6:0] = 7'h67;
      9:  r[6:0] = 7'h37;
      10: r[6:0] = 7'h17;
      11: r[6:0] = 7'h73;
      12: r[1:0] = 2'b11;
      default: r = r;
    endcase
    return r;
  endfunction

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    chk("rst_out_valid", 64'(a_out_valid | b_out_valid), 64'd0);
    chk("rst_out64_zero", 64'(|observe64()), 64'd0);
    chk("rst_out32_zero", 64'(|observe32()), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(a_in_ready & b_in_ready), 64'd1);

    // addi x1,x0,5 : no same-cycle bypass, visible one edge after the push
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 64'h8000_0000;
    in_inst   = 32'h0050_0093;
    step();
    in_valid = 1'b0;
    chk("addi_no_bypass", 64'(a_out_valid), 64'd0);
    step();
    chk("addi_valid", 64'(a_out_valid), 64'd1);
    chk("addi_wb", 64'(a_wb), 64'd2);
    chk("addi_imm", a_imm, 64'd5);
    chk("addi_rs1_ena", 64'(a_rs1_ena), 64'd1);
    chk("addi_rs2_ena", 64'(a_rs2_ena), 64'd0);
    chk("addi_rd", 64'(a_rd), 64'd1);
    step();

    // sd x2,8(x1): legal on RV64, illegal on RV32
    send(32'h0020_B423);
    chk("sd64_mem", 64'(a_mem), 64'h5);
    chk("sd64_imm", a_imm, 64'd8);
    chk("sd64_rs2_ena", 64'(a_rs2_ena), 64'd1);
    chk("sd64_wb", 64'(a_wb), 64'd0);
    chk("sd32_illegal", 64'(b_illegal), 64'd1);
    chk("sd32_ctl_zero", 64'({b_mem, b_wb, b_rs1_ena, b_rs2_ena, b_imm_ena, b_store}), 64'd0);
    chk("sd32_imm_zero", 64'(b_imm), 64'd0);
    step();

    // beq x0,x0,-4
    send(32'hFE00_0EE3);
    chk("beq64_branch", 64'(a_branch), 64'd1);
    chk("beq64_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq32_imm", 64'(b_imm), 64'h0000_0000_FFFF_FFFC);
    step();

    // Capacity: DEPTH FIFO entries plus the output stage
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n_acc     = 0;
    for (int k = 0; k < 8; k++) begin
      in_pc   = 64'h1000 + 64'(n_acc * 4);
      in_inst = 32'h0000_0093 | (32'(n_acc) << 20);
      step();
    end
    chk("fill_accepted", 64'(n_acc), 64'd5);
    chk("fill_in_ready", 64'(a_in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_emit    = 0;
    for (int k = 0; k < 10; k++) step();
    chk("drain_emitted", 64'(n_emit), 64'd5);

    // Flush with a simultaneous push
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_pc   = {$urandom(), $urandom()};
      in_inst = rand_inst();
      step();
    end
    flush   = 1'b1;
    in_inst = 32'h0070_0393;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(a_out_valid), 64'd0);
    chk("flush_in_ready", 64'(a_in_ready), 64'd1);
    out_ready = 1'b1;
    n_emit    = 0;
    for (int k = 0; k < 4; k++) step();
    chk("flush_no_emit", 64'(n_emit), 64'd0);
    send(32'h0010_0113);

    // Asynchronous reset between edges with a full queue
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_pc   = {$urandom(), $urandom()};
      in_inst = rand_inst();
      step();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    fifo.delete();
    stage_v = 1'b0;
    #1;
    chk("arst_out_valid", 64'(a_out_valid | b_out_valid), 64'd0);
    chk("arst_in_ready", 64'(a_in_ready | b_in_ready), 64'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_release_in_ready", 64'(a_in_ready & b_in_ready), 64'd1);
    send(32'h0000_0013);
    step();

    // Randomized traffic with occasional flushes
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_pc     = {$urandom(), $urandom()};
      in_inst   = rand_inst();
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_idu_decq.md
YSYX_22051013_IDU_DECQ -- requirements
Module: ysyx_22051013_idu_decq

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width, 32 (RV32I) or 64 (RV64I).
REQ-002 SHALL have parameter DEPTH, default 4: instruction-queue entries, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid / in_ready, input / output, 1 / 1: fetch-side handshake.
REQ-006 SHALL have ports in_pc / in_inst, input / input, XLEN / 32: fetched PC and instruction.
REQ-007 SHALL have port flush, input, 1: discard all queued and staged instructions.
REQ-008 SHALL have ports out_valid / out_ready, output / input, 1 / 1: execute-side handshake.
REQ-009 SHALL have ports out_pc / out_inst, output / output, XLEN / 32: registered passthrough.
REQ-010 SHALL have ports out_rd / out_rs1 / out_rs2, output, 5 each: register indices inst[11:7], inst[19:15], inst[24:20].
REQ-011 SHALL have ports out_rs1_ena / out_rs2_ena / out_imm_ena, output, 1 each: operand enables.
REQ-012 SHALL have ports out_load / out_store / out_branch / out_jump, output, 1 each: instruction-class flags.
REQ-013 SHALL have ports out_wb_ctl / out_mem_ctl, output, 2 / 4: writeback select and memory op.
REQ-014 SHALL have port out_ext_imm, output, XLEN: sign-extended immediate.
REQ-015 SHALL have port out_illegal, output, 1: instruction is not decodable.

Function
REQ-016 SHALL buffer {pc,inst} in a DEPTH-entry circular FIFO; push on in_valid&in_ready, read/write pointers wrap modulo DEPTH.
REQ-017 SHALL drive in_ready = (count < DEPTH) & ~rst; no push into a full FIFO even when a pop occurs the same cycle.
REQ-018 SHALL decode the FIFO head combinationally; an output register SHALL load it when FIFO non-empty and (~out_valid | out_ready).
REQ-019 SHALL hold all out_* stable while out_valid & ~out_ready.
REQ-020 SHALL clear out_valid on a consumed handshake if FIFO is empty.
REQ-021 SHALL give latency: push at edge N, out_valid high after edge N+1 when stage empty; no same-cycle bypass.
REQ-022 SHALL provide capacity DEPTH+1 (FIFO plus output stage).
REQ-023 SHALL, on flush, at the next edge zero count and pointers, clear out_valid, and drop any simultaneous push; flush has priority over push and pop.
REQ-024 SHALL form immediates: I for LOAD/OP-IMM/OP-IMM-32/SYSTEM/JALR; U = {inst[31:12],12'b0} for LUI/AUIPC; J, B (bit0 = 0) and S per RV spec; all sign-extended to XLEN; 0 otherwise.
REQ-025 SHALL set rs1_ena for OP, OP-IMM, OP-32, OP-IMM-32, BRANCH, LOAD, STORE, JALR, and CSRRW/CSRRS/CSRRC.
REQ-026 SHALL set rs2_ena for OP, OP-32, BRANCH, STORE.
REQ-027 SHALL set imm_ena for LOAD, STORE, OP-IMM, OP-IMM-32, SYSTEM, LUI, AUIPC.
REQ-028 SHALL set out_wb_ctl: 01 for LOAD; 10 for OP/OP-IMM/OP-32/OP-IMM-32/SYSTEM/LUI/AUIPC/JAL/JALR; else 00.
REQ-029 SHALL set out_mem_ctl: SB 0001, SH 0010, SW 0100, SD 0101, LB 1001, LH 1010, LW 1011, LD 1100, LBU 1101, LHU 1110, LWU 1111; else 0000.
REQ-030 SHALL set out_jump for JAL/JALR and out_branch for BRANCH funct3 in {000,001,100,101,110,111}.
REQ-031 SHALL set out_illegal when any of the following holds: inst[1:0] != 11; unlisted opcode; undefined funct3; or, when XLEN=32, OP-32/OP-IMM-32/LD/SD/LWU.
REQ-032 SHALL, when out_illegal=1, force all enables, flags, wb_ctl, mem_ctl and ext_imm to 0; pc, inst and indices still pass.

Reset
REQ-033 SHALL, while rst=1, hold count=0, pointers=0, out_valid=0, all out_* registers=0, in_ready=0.
REQ-034 SHALL discard queue contents on rst asserted mid-operation; first push after rst deasserts follows REQ-021.

Verification
REQ-035 SHALL check: 0x00500093 (addi x1,x0,5), out_ready=1 -> out_valid one edge after push; wb_ctl=10, ext_imm=5, rs1_ena=1, rs2_ena=0, rd=1.
REQ-036 SHALL check: DEPTH=4, out_ready=0, in_valid held -> exactly 5 accepted, then in_ready=0; release -> 5 outputs in order.
REQ-037 SHALL check: 0x0020B423 (sd x2,8(x1)) -> XLEN=64: mem_ctl=0101, ext_imm=8, rs2_ena=1, wb_ctl=00; XLEN=32: illegal=1, all controls 0.
REQ-038 SHALL check: 0xFE000EE3 (beq x0,x0,-4) -> branch=1, ext_imm=all-ones except bit1:0 = 00 (-4).
REQ-039 SHALL check: 3 queued, flush with in_valid=1 -> next cycle out_valid=0, count=0, pushed instruction never emitted.
REQ-040 SHALL check: rst pulse between clock edges with full queue -> immediate out_valid=0, in_ready=0; after release in_ready=1.
